// File: rtl/i2c_cfg_if.sv
// Handshake bundle between the configuration sequencer and the i2c master.
interface i2c_cfg_if #(
    parameter int NBYTES = 3
);
    logic                        send;
    logic [$clog2(NBYTES)-1:0]   nbytes;
    logic [NBYTES*8-1:0]         data;
    logic                        ready;
    logic                        done;

    modport master (output send, nbytes, data, input ready, done);
    modport slave  (input send, nbytes, data, output ready, done);
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Walks a ROM table of I2C writes / delays / END and drives the i2c master one transaction at a time.
// Optional HPD_REINIT_EN adds hpd_i: a rising edge (re)starts the table, a falling edge clears cfg_done_o.
module i2c_cfg_sequencer #(
    parameter int NBYTES     = 3,
    parameter int ROM_AW     = 8,
    parameter int DELAY_UNIT = 100,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
`ifdef HPD_REINIT_EN
    input  logic                     hpd_i,
`endif
    output logic [ROM_AW-1:0]        rom_addr_o,
    input  logic [2+NBYTES*8-1:0]    rom_data_i,
    i2c_cfg_if.master                bus,
    output logic                     busy_o,
    output logic                     cfg_done_o,
    output logic [ROM_AW-1:0]        step_o
);
    localparam int DW  = NBYTES * 8;
    localparam int NBW = $clog2(NBYTES);
    localparam int CW  = 16 + $clog2(DELAY_UNIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_DONE
    } state_t;

    state_t            r_state, w_state_nxt, w_adv_state;
    logic [ROM_AW-1:0] r_ptr, w_ptr_nxt, w_adv_ptr;
    logic              r_send, w_send_nxt;
    logic [NBW-1:0]    r_nbytes, w_nbytes_nxt;
    logic [DW-1:0]     r_data, w_data_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_cfg_done, w_cfg_done_nxt;
    logic              r_busy;
    logic              r_auto, w_auto_nxt;
    logic              r_pend, w_pend_nxt;
    logic              w_hpd_rise, w_hpd_fall;

    logic [1:0]        w_len;
    logic [DW-1:0]     w_payload;
    logic [CW-1:0]     w_ticks;
    logic              w_last;

    assign w_len     = rom_data_i[DW+1:DW];
    assign w_payload = rom_data_i[DW-1:0];
    assign w_ticks   = CW'(rom_data_i[23:8]) * CW'(DELAY_UNIT);
    assign w_last    = (r_ptr == {ROM_AW{1'b1}});

`ifdef HPD_REINIT_EN
    logic [2:0] r_hpd_sync;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hpd_sync <= 3'b000;
        end else begin
            r_hpd_sync <= {r_hpd_sync[1:0], hpd_i};
        end
    end

    assign w_hpd_rise = r_hpd_sync[1] & ~r_hpd_sync[2];
    assign w_hpd_fall = ~r_hpd_sync[1] & r_hpd_sync[2];
`else
    assign w_hpd_rise = 1'b0;
    assign w_hpd_fall = 1'b0;
`endif

    // Where to go once an entry finishes: restart on a pending hot-plug, stop at the last slot.
    always_comb begin
        if (r_pend) begin
            w_adv_state = S_FETCH;
            w_adv_ptr   = {ROM_AW{1'b0}};
        end else if (w_last) begin
            w_adv_state = S_DONE;
            w_adv_ptr   = r_ptr;
        end else begin
            w_adv_state = S_FETCH;
            w_adv_ptr   = r_ptr + ROM_AW'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_send_nxt     = 1'b0;
        w_nbytes_nxt   = r_nbytes;
        w_data_nxt     = r_data;
        w_cnt_nxt      = r_cnt;
        w_cfg_done_nxt = r_cfg_done;
        w_auto_nxt     = r_auto;
        w_pend_nxt     = r_pend;
        case (r_state)
            S_IDLE: begin
                if (start_i || r_auto || r_pend || w_hpd_rise) begin
                    w_state_nxt    = S_FETCH;
                    w_ptr_nxt      = {ROM_AW{1'b0}};
                    w_cfg_done_nxt = 1'b0;
                    w_auto_nxt     = 1'b0;
                    w_pend_nxt     = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (w_len != 2'd0) begin
                    w_nbytes_nxt = NBW'(w_len);
                    w_data_nxt   = w_payload;
                    w_state_nxt  = S_ISSUE;
                end else if (w_payload[7:0] == 8'h00) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DELAY;
                    w_cnt_nxt   = (w_ticks == {CW{1'b0}}) ? {CW{1'b0}} : (w_ticks - CW'(1));
                end
            end
            S_ISSUE: begin
                if (bus.ready) begin
                    w_send_nxt  = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (bus.done) begin
                    w_state_nxt = w_adv_state;
                    w_ptr_nxt   = w_adv_ptr;
                    w_pend_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DELAY: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = w_adv_state;
                    w_ptr_nxt   = w_adv_ptr;
                    w_pend_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                w_cfg_done_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_pend_nxt     = w_pend_nxt | (w_hpd_rise & (r_state != S_IDLE));
        w_cfg_done_nxt = w_cfg_done_nxt & ~w_hpd_fall;
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_ptr      <= {ROM_AW{1'b0}};
            r_send     <= 1'b0;
            r_nbytes   <= {NBW{1'b0}};
            r_data     <= {DW{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_cfg_done <= 1'b0;
            r_busy     <= 1'b0;
            r_auto     <= AUTO_START;
            r_pend     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_send     <= w_send_nxt;
            r_nbytes   <= w_nbytes_nxt;
            r_data     <= w_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cfg_done <= w_cfg_done_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_auto     <= w_auto_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    assign rom_addr_o = r_ptr;
    assign step_o     = r_ptr;
    assign busy_o     = r_busy;
    assign cfg_done_o = r_cfg_done;
    assign bus.send   = r_send;
    assign bus.nbytes = r_nbytes;
    assign bus.data   = r_data;
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer with a small ROM and i2c master model.
module tb_i2c_cfg_sequencer;
    localparam int NB = 3;
    localparam int AW = 4;
    localparam int DU = 100;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
`ifdef HPD_REINIT_EN
    logic hpd_i = 1'b0;
`endif
    logic [AW-1:0]     rom_addr;
    logic [2+NB*8-1:0] rom_q;
    logic [2+NB*8-1:0] rom [0:15];
    logic              busy, cfg_done;
    logic [AW-1:0]     step;
    logic              hold_low = 1'b0;
    logic              stray_done = 1'b0;

    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    int                m_cnt = 0;
    int                n_send = 0;
    logic [NB*8-1:0]   cap_data [0:15];
    logic [1:0]        cap_nb [0:15];

    int n_pass = 0;
    int n_checks = 0;
    int base;
    int k;

    i2c_cfg_if #(.NBYTES(NB)) bus();

    i2c_cfg_sequencer #(.NBYTES(NB), .ROM_AW(AW), .DELAY_UNIT(DU), .AUTO_START(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
`ifdef HPD_REINIT_EN
        .hpd_i      (hpd_i),
`endif
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_q),
        .bus        (bus),
        .busy_o     (busy),
        .cfg_done_o (cfg_done),
        .step_o     (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr];

    // i2c master model: 10-cycle transaction, done pulse, ready when idle.
    always @(posedge clk) begin
        if (rst_i) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (bus.send) begin
                n_send <= n_send + 1;
                cap_data[n_send[3:0]] <= bus.data;
                cap_nb[n_send[3:0]]   <= bus.nbytes;
                m_busy <= 1'b1;
                m_cnt  <= 10;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign bus.ready = !m_busy && !hold_low;
    assign bus.done  = m_done || stray_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!(cfg_done && !busy) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_timeout"}, 32'(c < 3000), 32'd1);
    endtask

    task automatic wait_send(input int target, input string tag);
        int c = 0;
        while (n_send < target && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_timeout"}, 32'(c < 500), 32'd1);
    endtask

    // Start a run and count negedges until step_o reaches 1; optional stray done mid-delay.
    task automatic run_delay(input bit stray, output int cnt);
        cnt = 0;
        @(negedge clk) start_i = 1'b1;
        do begin
            @(negedge clk);
            cnt++;
            start_i    = 1'b0;
            stray_done = stray && (cnt == 50);
        end while (step != 4'd1 && cnt < 2000);
        stray_done = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 26'd0;
    endtask

    initial begin
        clear_rom();
        rom[0] = {2'd2, 24'h0020E8};
        rom[1] = {2'd3, 24'h104172};
        tick(3);
        chk("rst_send", 32'(bus.send), 32'd0);
        chk("rst_nbytes", 32'(bus.nbytes), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);

        // 1: auto start after reset
        base = n_send;
        rst_i = 1'b0;
        k = 0;
        while (n_send == base && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t1_latency", 32'(k >= 3 && k < 100), 32'd1);
        wait_done("t1");
        chk("t1_nsend", 32'(n_send - base), 32'd2);
        chk("t1_nb0", 32'(cap_nb[base % 16]), 32'd2);
        chk("t1_data0", 32'(cap_data[base % 16]), 32'h0020E8);
        chk("t1_nb1", 32'(cap_nb[(base + 1) % 16]), 32'd3);
        chk("t1_data1", 32'(cap_data[(base + 1) % 16]), 32'h104172);
        chk("t1_cfg_done", 32'(cfg_done), 32'd1);
        chk("t1_step", 32'(step), 32'd2);

        // 2: ready held low in ISSUE
        base = n_send;
        hold_low = 1'b1;
        pulse_start();
        tick(50);
        chk("t2_nosend", 32'(n_send - base), 32'd0);
        chk("t2_send_low", 32'(bus.send), 32'd0);
        chk("t2_data_stable", 32'(bus.data), 32'h0020E8);
        chk("t2_nbytes_stable", 32'(bus.nbytes), 32'd2);
        hold_low = 1'b0;
        tick(5);
        chk("t2_one_send", 32'(n_send - base), 32'd1);
        chk("t2_wait_data", 32'(bus.data), 32'h0020E8);
        wait_done("t2");
        chk("t2_nsend", 32'(n_send - base), 32'd2);
        chk("t2_data1", 32'(cap_data[(base + 1) % 16]), 32'h104172);

        // 3: delay of 3 ticks = 300 cycles in DELAY
        clear_rom();
        rom[0] = {2'd0, 24'h000301};
        rom[1] = {2'd2, 24'h0020E8};
        base = n_send;
        run_delay(1'b0, k);
        chk("t3_delay_cycles", 32'(k), 32'd303);
        wait_done("t3");
        chk("t3_nsend", 32'(n_send - base), 32'd1);
        chk("t3_data", 32'(cap_data[base % 16]), 32'h0020E8);
        chk("t3_step", 32'(step), 32'd2);

        // 4: stray done in DELAY, start during WAIT
        base = n_send;
        run_delay(1'b1, k);
        chk("t4_delay_cycles", 32'(k), 32'd303);
        wait_send(base + 1, "t4_send");
        tick(2);
        pulse_start();
        chk("t4_step_wait", 32'(step), 32'd1);
        chk("t4_busy_wait", 32'(busy), 32'd1);
        wait_done("t4");
        chk("t4_step", 32'(step), 32'd2);
        chk("t4_nsend", 32'(n_send - base), 32'd1);
        chk("t4_cfg_done", 32'(cfg_done), 32'd1);

        // 5: reset during WAIT, auto rerun
        clear_rom();
        rom[0] = {2'd2, 24'h0020E8};
        rom[1] = {2'd3, 24'h104172};
        base = n_send;
        pulse_start();
        wait_send(base + 1, "t5_send");
        tick(3);
        rst_i = 1'b1;
        @(negedge clk);
        chk("t5_send", 32'(bus.send), 32'd0);
        chk("t5_nbytes", 32'(bus.nbytes), 32'd0);
        chk("t5_data", 32'(bus.data), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cfg_done", 32'(cfg_done), 32'd0);
        chk("t5_step", 32'(step), 32'd0);
        rst_i = 1'b0;
        base = n_send;
        tick(2);
        wait_done("t5");
        chk("t5_nsend", 32'(n_send - base), 32'd2);
        chk("t5_data1", 32'(cap_data[(base + 1) % 16]), 32'h104172);

        // boundary: table full of zero-length delays, no END
        for (int i = 0; i < 16; i++) rom[i] = {2'd0, 24'h000001};
        base = n_send;
        pulse_start();
        wait_done("wrap");
        chk("wrap_step", 32'(step), 32'd15);
        chk("wrap_rom_addr", 32'(rom_addr), 32'd15);
        chk("wrap_nsend", 32'(n_send - base), 32'd0);
        chk("wrap_cfg_done", 32'(cfg_done), 32'd1);

`ifdef HPD_REINIT_EN
        // 6: hot-plug rise during entry 0 restarts the table; fall clears cfg_done
        clear_rom();
        rom[0] = {2'd2, 24'h0020E8};
        rom[1] = {2'd3, 24'h104172};
        base = n_send;
        pulse_start();
        wait_send(base + 1, "t6_send");
        hpd_i = 1'b1;
        wait_done("t6");
        chk("t6_nsend", 32'(n_send - base), 32'd3);
        chk("t6_data1", 32'(cap_data[(base + 1) % 16]), 32'h0020E8);
        chk("t6_data2", 32'(cap_data[(base + 2) % 16]), 32'h104172);
        chk("t6_cfg_done", 32'(cfg_done), 32'd1);
        hpd_i = 1'b0;
        tick(5);
        chk("t6_cfg_clr", 32'(cfg_done), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
